// File: rtl/abc_selftest.sv
// abc_selftest: sequential self-test stage for the abc block (y = AB + !BC).
// Steps {a,b,c} through vectors 0..7 and holds each vector for SETTLE cycles.
// On the last cycle of each hold it compares y against EXPECTED[index].
// Mismatches are counted in err_count and flagged per vector in fail_mask.
// Optional feature macro: ABC_SELFTEST_SYNC_EN. When defined, y passes through
// a two-flop synchroniser first, and each vector is held for SETTLE+2 cycles.
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | vector applied, settle counter running
// S_DONE | run complete, results held until the next start
module abc_selftest #(
   parameter logic [7:0] EXPECTED = 8'b1110_0010,
   parameter int         SETTLE   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [7:0] fail_mask
);

`ifdef ABC_SELFTEST_SYNC_EN
   localparam int HOLD = SETTLE + 2;
`else
   localparam int HOLD = SETTLE;
`endif
   localparam logic [4:0] CNT_LAST = 5'(HOLD - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_idx;
   logic [4:0] r_cnt;
   logic [3:0] r_err;
   logic [7:0] r_mask;
   logic       r_pass;
   logic       w_y;
   logic       w_accept;
   logic       w_cmp;
   logic       w_miss;
   logic       w_last;

`ifdef ABC_SELFTEST_SYNC_EN
   logic r_y_s1;
   logic r_y_s2;

   // two-flop synchroniser on the returned response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_s1 <= 1'b0;
         r_y_s2 <= 1'b0;
      end else begin
         r_y_s1 <= y;
         r_y_s2 <= r_y_s1;
      end
   end

   assign w_y = r_y_s2;
`else
   assign w_y = y;
`endif

   // start is only honoured outside a run, so a run cannot be restarted or extended
   assign w_accept = start && (r_state != S_RUN);
   assign w_cmp    = (r_state == S_RUN) && (r_cnt == CNT_LAST);
   assign w_miss   = (w_y != EXPECTED[r_idx]);
   assign w_last   = (r_idx == 3'd7);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
         S_RUN:   if (w_cmp && w_last) w_state_nxt = S_DONE;
         S_DONE:  if (w_accept) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // vector index, settle counter and result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= 3'd0;
         r_cnt  <= 5'd0;
         r_err  <= 4'd0;
         r_mask <= 8'd0;
         r_pass <= 1'b0;
      end else if (w_accept) begin
         r_idx  <= 3'd0;
         r_cnt  <= 5'd0;
         r_err  <= 4'd0;
         r_mask <= 8'd0;
         r_pass <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (w_cmp) begin
            r_cnt <= 5'd0;
            if (w_miss) begin
               r_mask[r_idx] <= 1'b1;
               r_err         <= r_err + 4'd1;
            end
            // the index stays at 7 in DONE so a,b,c hold 1,1,1
            if (w_last) r_pass <= (r_err == 4'd0) && !w_miss;
            else        r_idx  <= r_idx + 3'd1;
         end else begin
            r_cnt <= r_cnt + 5'd1;
         end
      end
   end

   assign {a, b, c}  = r_idx;
   assign busy       = (r_state == S_RUN);
   assign done       = (r_state == S_DONE);
   assign pass       = r_pass;
   assign err_count  = r_err;
   assign fail_mask  = r_mask;

endmodule
